// File: rtl/regfile_defs.sv
// Shared definitions for the 2-read/1-write register file.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents:
//   clog2()        - ceiling log2, used to size address buses from DEPTH
//   RF_RST_DATA    - value of storage and read-data registers under reset
//   RF_RST_VALID   - value of the read-valid flags under reset
package regfile_defs;

  // Ceiling log2 for elaboration-time sizing. DEPTH is always >= 2, so the
  // result is at least 1 and address buses never collapse to zero width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  localparam int   RF_RST_DATA  = 0;
  localparam logic RF_RST_VALID = 1'b0;

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port of the register file.
// Latency: 1 cycle from re to rdata/rvalid; one result per cycle when re is held.
// Backpressure: none; every request is answered, rdata holds when re=0.
//
// Ports:
//   clk, reset         rising-edge clock, async active-low reset
//   mem_flat           all DEPTH entries, entry i at [i*WIDTH +: WIDTH]
//   wr_en              write accepted this cycle (already range/zero/clr filtered)
//   waddr, wdata       write bus, used for the same-cycle bypass
//   clr                synchronous clear-all; a clearing cycle never bypasses
//   re, raddr          read request and address
//   rdata, rvalid      registered read result and its valid flag
module regfile_rdport
  import regfile_defs::*;
#(
  parameter int  WIDTH    = 16,
  parameter int  DEPTH    = 8,
  parameter bit  BYPASS   = 1'b1,
  parameter bit  ZERO_REG = 1'b0,
  localparam int AW       = clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DEPTH*WIDTH-1:0] mem_flat,
  input  logic                   wr_en,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   clr,
  input  logic                   re,
  input  logic [AW-1:0]          raddr,
  output logic [WIDTH-1:0]       rdata,
  output logic                   rvalid
);

  // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  logic             in_range;
  logic             zero_hit;
  logic             byp_hit;
  logic [WIDTH-1:0] stored;
  logic [WIDTH-1:0] rd_src;

  always_comb begin
    in_range = ({1'b0, raddr} < DEPTH_W);
    zero_hit = ZERO_REG && (raddr == '0);
    // wr_en already excludes clr; clr is repeated here so the bypass can
    // never leak data through a clearing edge even if wr_en's meaning changes.
    byp_hit  = BYPASS && wr_en && !clr && (waddr == raddr);

    // Explicit compare mux rather than a variable part-select: DEPTH need not
    // be a power of two, so raddr can point past the end of mem_flat.
    stored = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == i[AW-1:0]) begin
        stored = mem_flat[i*WIDTH +: WIDTH];
      end
    end

    if (!in_range) begin
      rd_src = '0;
    end else if (zero_hit) begin
      rd_src = '0;
    end else if (byp_hit) begin
      rd_src = wdata;
    end else begin
      rd_src = stored;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata  <= WIDTH'(RF_RST_DATA);
      rvalid <= RF_RST_VALID;
    end else begin
      rvalid <= re;
      if (re) begin
        rdata <= rd_src;
      end
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised register file: DEPTH x WIDTH, one write port, two registered read ports.
// Latency: writes visible to reads on the next edge (or same edge with BYPASS=1); reads 1 cycle.
// Backpressure: none; writes and reads are accepted every cycle, dropped writes are silent.
//
// Ports:
//   clk, reset                      rising-edge clock, async active-low reset
//   we, waddr, wdata                write port (dropped if waddr>=DEPTH or entry 0 with ZERO_REG)
//   clr                             synchronous clear of all entries and dirty; beats we
//   re_a, raddr_a, rdata_a, rvalid_a  read port A
//   re_b, raddr_b, rdata_b, rvalid_b  read port B
//   dirty                           bit i set once entry i is written, cleared by reset/clr
module regfile_2r1w
  import regfile_defs::*;
#(
  parameter int  WIDTH    = 16,
  parameter int  DEPTH    = 8,
  parameter bit  BYPASS   = 1'b1,
  parameter bit  ZERO_REG = 1'b0,
  localparam int AW       = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             clr,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  output logic             rvalid_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rvalid_b,
  output logic [DEPTH-1:0] dirty
);

  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  logic                   waddr_ok;
  logic                   wr_en;
  logic [DEPTH*WIDTH-1:0] mem_flat;

  // A write lands only if it is in range, not aimed at a hardwired-zero
  // entry, and not overridden by a clear in the same cycle.
  always_comb begin
    waddr_ok = ({1'b0, waddr} < DEPTH_W) && !(ZERO_REG && (waddr == '0));
    wr_en    = we && !clr && waddr_ok;
  end

  // Each entry keeps its own data and dirty flop so there is exactly one
  // process driving each storage bit.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    localparam logic [AW-1:0] IDX = AW'(i);

    logic [WIDTH-1:0] q;
    logic             d;
    logic             sel;

    assign sel = wr_en && (waddr == IDX);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        q <= WIDTH'(RF_RST_DATA);
        d <= 1'b0;
      end else if (clr) begin
        q <= '0;
        d <= 1'b0;
      end else if (sel) begin
        q <= wdata;
        d <= 1'b1;
      end
    end

    assign mem_flat[i*WIDTH +: WIDTH] = q;
    assign dirty[i]                   = d;
  end

  regfile_rdport #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_rdport_a (
    .clk      (clk),
    .reset    (reset),
    .mem_flat (mem_flat),
    .wr_en    (wr_en),
    .waddr    (waddr),
    .wdata    (wdata),
    .clr      (clr),
    .re       (re_a),
    .raddr    (raddr_a),
    .rdata    (rdata_a),
    .rvalid   (rvalid_a)
  );

  regfile_rdport #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_rdport_b (
    .clk      (clk),
    .reset    (reset),
    .mem_flat (mem_flat),
    .wr_en    (wr_en),
    .waddr    (waddr),
    .wdata    (wdata),
    .clr      (clr),
    .re       (re_b),
    .raddr    (raddr_b),
    .rdata    (rdata_b),
    .rvalid   (rvalid_b)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: three instances share one stimulus stream.
//   d0: defaults (16x8, BYPASS=1, ZERO_REG=0)
//   d1: BYPASS=0
//   d2: DEPTH=6, ZERO_REG=1, BYPASS=1
module tb_regfile_2r1w;

  logic        clk;
  logic        reset;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic        clr;
  logic        re_a;
  logic [2:0]  raddr_a;
  logic        re_b;
  logic [2:0]  raddr_b;

  logic [15:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1, rdata_a2, rdata_b2;
  logic        rvalid_a0, rvalid_b0, rvalid_a1, rvalid_b1, rvalid_a2, rvalid_b2;
  logic [7:0]  dirty0, dirty1;
  logic [5:0]  dirty2;

  int tests = 0;
  int fails = 0;

  regfile_2r1w u_d0 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a0), .rvalid_a(rvalid_a0),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b0), .rvalid_b(rvalid_b0),
    .dirty(dirty0)
  );

  regfile_2r1w #(.BYPASS(1'b0)) u_d1 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a1), .rvalid_a(rvalid_a1),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b1), .rvalid_b(rvalid_b1),
    .dirty(dirty1)
  );

  regfile_2r1w #(.DEPTH(6), .ZERO_REG(1'b1)) u_d2 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a2), .rvalid_a(rvalid_a2),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b2), .rvalid_b(rvalid_b2),
    .dirty(dirty2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; we = 1'b0; waddr = '0; wdata = '0; clr = 1'b0;
    re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0;

    // Reset held for 3 cycles
    repeat (3) tick();
    chk("rst_rdata_a0",  32'(rdata_a0),  32'h0);
    chk("rst_rvalid_a0", 32'(rvalid_a0), 32'h0);
    chk("rst_rvalid_b0", 32'(rvalid_b0), 32'h0);
    chk("rst_dirty0",    32'(dirty0),    32'h0);

    // Release, read addr 3
    reset = 1'b1;
    re_a = 1'b1; raddr_a = 3'd3;
    tick();
    chk("rd3_rdata_a0",  32'(rdata_a0),  32'h0);
    chk("rd3_rvalid_a0", 32'(rvalid_a0), 32'h1);
    chk("rd3_dirty0",    32'(dirty0),    32'h0);
    re_a = 1'b0;

    // Write BEEF to addr 5, read back on both ports
    we = 1'b1; waddr = 3'd5; wdata = 16'hBEEF;
    tick();
    we = 1'b0;
    chk("wr5_dirty0", 32'(dirty0), 32'h20);
    chk("wr5_dirty2", 32'(dirty2), 32'h20);
    re_a = 1'b1; raddr_a = 3'd5; re_b = 1'b1; raddr_b = 3'd5;
    tick();
    chk("rd5_rdata_a0",  32'(rdata_a0),  32'hBEEF);
    chk("rd5_rdata_b0",  32'(rdata_b0),  32'hBEEF);
    chk("rd5_rvalid_a0", 32'(rvalid_a0), 32'h1);
    chk("rd5_rvalid_b0", 32'(rvalid_b0), 32'h1);
    chk("rd5_rdata_a2",  32'(rdata_a2),  32'hBEEF);
    re_a = 1'b0; re_b = 1'b0;
    tick();
    chk("idle_rvalid_a0", 32'(rvalid_a0), 32'h0);
    chk("idle_rvalid_b0", 32'(rvalid_b0), 32'h0);
    chk("idle_hold_a0",   32'(rdata_a0),  32'hBEEF);

    // Same-cycle write/read of addr 2
    we = 1'b1; waddr = 3'd2; wdata = 16'h1234; re_a = 1'b1; raddr_a = 3'd2;
    tick();
    chk("byp_on_a0",  32'(rdata_a0), 32'h1234);
    chk("byp_off_a1", 32'(rdata_a1), 32'h0);
    we = 1'b0;
    tick();
    chk("after_byp_a0", 32'(rdata_a0), 32'h1234);
    chk("after_byp_a1", 32'(rdata_a1), 32'h1234);
    re_a = 1'b0;

    // Fill all entries with A5A0+i
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; waddr = 3'(i); wdata = 16'hA5A0 + 16'(i);
      tick();
    end
    we = 1'b0;
    chk("fill_dirty0", 32'(dirty0), 32'hFF);
    chk("fill_dirty1", 32'(dirty1), 32'hFF);
    chk("fill_dirty2", 32'(dirty2), 32'h3E);

    // Clear beats a simultaneous write; same-cycle read sees pre-clear data
    clr = 1'b1; we = 1'b1; waddr = 3'd1; wdata = 16'hFFFF; re_a = 1'b1; raddr_a = 3'd1;
    tick();
    clr = 1'b0; we = 1'b0;
    chk("clr_rd_a0",    32'(rdata_a0), 32'hA5A1);
    chk("clr_rd_a1",    32'(rdata_a1), 32'hA5A1);
    chk("clr_rd_a2",    32'(rdata_a2), 32'hA5A1);
    chk("clr_dirty0",   32'(dirty0),   32'h0);
    chk("clr_dirty2",   32'(dirty2),   32'h0);
    for (int i = 0; i < 8; i++) begin
      re_a = 1'b1; raddr_a = 3'(i); re_b = 1'b1; raddr_b = 3'(7 - i);
      tick();
      chk("post_clr_a0", 32'(rdata_a0), 32'h0);
      chk("post_clr_b0", 32'(rdata_b0), 32'h0);
    end
    re_a = 1'b0; re_b = 1'b0;

    // Boundaries on the 6-entry instance
    we = 1'b1; waddr = 3'd3; wdata = 16'h3333;
    tick();
    we = 1'b0;
    re_a = 1'b1; raddr_a = 3'd3;
    tick();
    chk("rd3_a2", 32'(rdata_a2), 32'h3333);
    we = 1'b1; waddr = 3'd7; wdata = 16'hDEAD;
    re_a = 1'b1; raddr_a = 3'd7; re_b = 1'b1; raddr_b = 3'd6;
    tick();
    we = 1'b0;
    chk("oor_byp_a0",    32'(rdata_a0),  32'hDEAD);
    chk("oor_rd7_a2",    32'(rdata_a2),  32'h0);
    chk("oor_rvalid_a2", 32'(rvalid_a2), 32'h1);
    chk("oor_rd6_b2",    32'(rdata_b2),  32'h0);
    chk("oor_rvalid_b2", 32'(rvalid_b2), 32'h1);
    chk("oor_dirty2",    32'(dirty2),    32'h08);
    chk("oor_dirty0",    32'(dirty0),    32'h88);
    re_b = 1'b0;

    // Hardwired zero entry on d2
    raddr_a = 3'd3;
    tick();
    chk("pre_zero_a2", 32'(rdata_a2), 32'h3333);
    we = 1'b1; waddr = 3'd0; wdata = 16'h7777; raddr_a = 3'd0;
    tick();
    we = 1'b0;
    chk("zero_byp_a0",  32'(rdata_a0), 32'h7777);
    chk("zero_old_a1",  32'(rdata_a1), 32'h0);
    chk("zero_rd_a2",   32'(rdata_a2), 32'h0);
    tick();
    chk("zero_next_a0", 32'(rdata_a0), 32'h7777);
    chk("zero_next_a1", 32'(rdata_a1), 32'h7777);
    chk("zero_next_a2", 32'(rdata_a2), 32'h0);
    chk("zero_dirty2",  32'(dirty2),   32'h08);
    chk("zero_dirty0",  32'(dirty0),   32'h89);

    // Async reset with reads in flight
    re_a = 1'b1; raddr_a = 3'd3; re_b = 1'b1; raddr_b = 3'd0;
    tick();
    chk("inflight_a0",   32'(rdata_a0),  32'h3333);
    chk("inflight_b0",   32'(rdata_b0),  32'h7777);
    chk("inflight_vb0",  32'(rvalid_b0), 32'h1);
    #3 reset = 1'b0;
    #1;
    chk("arst_rdata_a0",  32'(rdata_a0),  32'h0);
    chk("arst_rdata_b0",  32'(rdata_b0),  32'h0);
    chk("arst_rvalid_a0", 32'(rvalid_a0), 32'h0);
    chk("arst_rvalid_b0", 32'(rvalid_b0), 32'h0);
    chk("arst_dirty0",    32'(dirty0),    32'h0);
    chk("arst_rdata_a2",  32'(rdata_a2),  32'h0);
    chk("arst_dirty2",    32'(dirty2),    32'h0);
    #1 reset = 1'b1;
    tick();
    chk("post_arst_a0",  32'(rdata_a0),  32'h0);
    chk("post_arst_va0", 32'(rvalid_a0), 32'h1);
    chk("post_arst_b0",  32'(rdata_b0),  32'h0);
    re_a = 1'b0; re_b = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
